// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment codes {g,f,e,d,c,b,a}, active-high
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - digit/segment bundle between a BCD source and the scan display
interface bcd_scan_display_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   an;
  seg_t                    seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output en, digits, dp_in,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  en, digits, dp_in,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to 7-segment decoder; A..F show a dash
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - multiplexed 7-segment scanner with per-frame digit snapshot
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4
) (
  input logic               clk,
  input logic               rst,
  bcd_scan_display_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic       tick;
  logic       wrap;
  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_blank;
  seg_t       dec_seg;

  always_comb begin
    tick = bus.en && (presc_q == PRESC_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    presc_d = presc_q;
    if (tick)
      presc_d = '0;
    else if (bus.en)
      presc_d = presc_q + 1'b1;

    idx_d = idx_q;
    if (wrap)
      idx_d = '0;
    else if (tick)
      idx_d = idx_q + 1'b1;

    // Snapshot only at the frame wrap so a mid-scan rollover never tears.
    snap_d    = wrap ? bus.digits : snap_q;
    snap_dp_d = wrap ? bus.dp_in  : snap_dp_q;
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = snap_q[4*i +: 4];
        cur_dp    = snap_dp_q[i];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_run;

  // Walk down from the top digit; digit 0 is never part of the mask.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (snap_q[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i))
        cur_blank = blank[i];
    end
  end
`else
  always_comb cur_blank = 1'b0;
`endif

  always_comb begin
    an_d  = '0;
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    if (bus.en) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        an_d[i] = (idx_q == IW'(i));
      seg_d = cur_blank ? SEG_OFF : dec_seg;
      dp_d  = cur_dp;
    end
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      snap_dp_q    <= '0;
      an_q         <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      snap_dp_q    <= snap_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed checks of bcd_scan_display in 4-digit and 1-digit builds
module tb_bcd_scan_display;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h00;
`else
  localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

  logic [6:0] dec_tbl [16];

  bcd_scan_display_if #(.NUM_DIGITS(4)) bus_b ();
  bcd_scan_display_if #(.NUM_DIGITS(1)) bus_a ();

  bcd_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  bcd_scan_display #(.NUM_DIGITS(1), .REFRESH_DIV(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic [3:0] an, input logic [6:0] seg,
                       input logic dp, input logic fd);
    check({tag, ".an"}, 16'(bus_b.an), 16'(an));
    check({tag, ".seg"}, 16'(bus_b.seg), 16'(seg));
    check({tag, ".dp"}, 16'(bus_b.dp), 16'(dp));
    check({tag, ".fd"}, 16'(bus_b.frame_done), 16'(fd));
  endtask

  initial begin
    dec_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    rst          = 1'b1;
    bus_b.en     = 1'b1;
    bus_b.digits = 16'h1234;
    bus_b.dp_in  = 4'b0000;
    bus_a.en     = 1'b1;
    bus_a.digits = 4'h0;
    bus_a.dp_in  = 1'b0;

    // reset dominates en
    cyc(2);
    chk_b("rst", 4'b0000, 7'h00, 1'b0, 1'b0);

    // first frame shows the cleared snapshot
    rst = 1'b0;
    cyc(1);
    chk_b("e1", 4'b0001, 7'h3F, 1'b0, 1'b0);
    cyc(14);
    chk_b("e15", 4'b1000, 7'h3F, 1'b0, 1'b0);
    cyc(1);
    chk_b("wrap16", 4'b1000, 7'h3F, 1'b0, 1'b1);
    cyc(1);
    chk_b("e17", 4'b0001, 7'h66, 1'b0, 1'b0);
    cyc(4);
    chk_b("e21", 4'b0010, 7'h4F, 1'b0, 1'b0);

    // change input while idx=1: rest of frame keeps 1234
    bus_b.digits = 16'h5678;
    bus_b.dp_in  = 4'b0010;
    cyc(4);
    chk_b("e25", 4'b0100, 7'h5B, 1'b0, 1'b0);
    cyc(4);
    chk_b("e29", 4'b1000, 7'h06, 1'b0, 1'b0);
    cyc(3);
    chk_b("wrap32", 4'b1000, 7'h06, 1'b0, 1'b1);
    cyc(1);
    chk_b("e33", 4'b0001, 7'h7F, 1'b0, 1'b0);

    // freeze mid-slot (presc=2, idx=0 after next edge)
    cyc(1);
    chk_b("e34", 4'b0001, 7'h7F, 1'b0, 1'b0);
    bus_b.en = 1'b0;
    cyc(1);
    chk_b("off1", 4'b0000, 7'h00, 1'b0, 1'b0);
    cyc(9);
    chk_b("off10", 4'b0000, 7'h00, 1'b0, 1'b0);
    bus_b.en = 1'b1;
    cyc(2);
    chk_b("resume2", 4'b0001, 7'h7F, 1'b0, 1'b0);
    cyc(1);
    chk_b("resume3", 4'b0010, 7'h07, 1'b1, 1'b0);

    // reset mid-frame clears snapshot
    rst = 1'b1;
    cyc(1);
    chk_b("midrst", 4'b0000, 7'h00, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk_b("r_e1", 4'b0001, 7'h3F, 1'b0, 1'b0);
    cyc(4);
    chk_b("r_e5", 4'b0010, 7'h3F, 1'b0, 1'b0);
    cyc(11);
    chk_b("r_wrap", 4'b1000, 7'h3F, 1'b0, 1'b1);
    cyc(1);
    chk_b("r_e17", 4'b0001, 7'h7F, 1'b0, 1'b0);

    // leading-zero pattern 0070 with dp on digit 2
    bus_b.digits = 16'h0070;
    bus_b.dp_in  = 4'b0100;
    cyc(15);
    chk_b("lz_wrap", 4'b1000, 7'h6D, 1'b0, 1'b1);
    cyc(1);
    chk_b("lz_d0", 4'b0001, 7'h3F, 1'b0, 1'b0);
    cyc(4);
    chk_b("lz_d1", 4'b0010, 7'h07, 1'b0, 1'b0);
    cyc(4);
    chk_b("lz_d2", 4'b0100, LZ_SEG, 1'b1, 1'b0);
    cyc(4);
    chk_b("lz_d3", 4'b1000, LZ_SEG, 1'b0, 1'b0);

    bus_b.digits = 16'h0000;
    bus_b.dp_in  = 4'b0000;
    cyc(3);
    chk_b("z_wrap", 4'b1000, LZ_SEG, 1'b0, 1'b1);
    cyc(1);
    chk_b("z_d0", 4'b0001, 7'h3F, 1'b0, 1'b0);
    cyc(4);
    chk_b("z_d1", 4'b0010, LZ_SEG, 1'b0, 1'b0);

    // single-digit, divide-by-1: every enabled cycle wraps
    for (int d = 0; d < 16; d++) begin
      bus_a.digits = 4'(d);
      cyc(2);
      check($sformatf("a_seg%0d", d), 16'(bus_a.seg), 16'(dec_tbl[d]));
      check($sformatf("a_an%0d", d), 16'(bus_a.an), 16'h0001);
      check($sformatf("a_fd%0d", d), 16'(bus_a.frame_done), 16'h0001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
